// File: rtl/shift_sub_divider_if.sv
// ============================================================================
// shift_sub_divider_if : operand/result handshake bundle for shift_sub_divider
// Rev 1.0
// ============================================================================
`default_nettype none

interface shift_sub_divider_if #(
    parameter int WIDTH_N = 64,
    parameter int WIDTH_D = 32
);
    logic               iValid_Data;
    logic               iAck;
    logic [WIDTH_N-1:0] iDividend;
    logic [WIDTH_D-1:0] iDivisor;
    logic               oBusy;
    logic               oDone;
    logic [WIDTH_N-1:0] oQuotient;
    logic [WIDTH_D-1:0] oRemainder;
    logic               oDivZero;

    modport master (
        output iValid_Data, iAck, iDividend, iDivisor,
        input  oBusy, oDone, oQuotient, oRemainder, oDivZero
    );

    modport slave (
        input  iValid_Data, iAck, iDividend, iDivisor,
        output oBusy, oDone, oQuotient, oRemainder, oDivZero
    );
endinterface

`default_nettype wire

// File: rtl/shift_sub_divider.sv
// ============================================================================
// shift_sub_divider : restoring shift-subtract unsigned divider, 1 bit/clock.
// Optional macro DIVIDER_DIVZERO_CHECK_EN: zero divisor skips RUN, flags oDivZero.
// Rev 1.0
// ============================================================================
`default_nettype none

module shift_sub_divider #(
    parameter int WIDTH_N = 64,
    parameter int WIDTH_D = 32
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    shift_sub_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH_N + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_DONE    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               w_start;
    logic               w_last;
    logic               w_zero_skip;

    logic [WIDTH_N-1:0] r_q;
    logic [WIDTH_D:0]   r_rem;
    logic [WIDTH_D-1:0] r_div;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH_N-1:0] r_quot_out;
    logic [WIDTH_D-1:0] r_rem_out;

    logic [WIDTH_D:0]   w_shift;
    logic [WIDTH_D:0]   w_sub;
    logic               w_ge;
    logic [WIDTH_N-1:0] w_q_next;
    logic [WIDTH_D:0]   w_rem_next;
    logic               w_unused;

    // One restoring step: bring in the next dividend bit, subtract if it fits.
    assign w_shift    = {r_rem[WIDTH_D-1:0], r_q[WIDTH_N-1]};
    assign w_ge       = (w_shift >= {1'b0, r_div});
    assign w_sub      = w_shift - {1'b0, r_div};
    assign w_q_next   = {r_q[WIDTH_N-2:0], w_ge};
    assign w_rem_next = w_ge ? w_sub : w_shift;
    assign w_unused   = r_rem[WIDTH_D];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_start     = 1'b0;
        w_last      = 1'b0;
        w_zero_skip = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.iValid_Data) begin
                    w_start = 1'b1;
                    w_next  = S_RUN;
`ifdef DIVIDER_DIVZERO_CHECK_EN
                    if (bus.iDivisor == '0) begin
                        w_zero_skip = 1'b1;
                        w_next      = S_DONE;
                    end
`endif
                end
            end
            S_RUN: begin
                if (r_cnt == CW'(1)) begin
                    w_last = 1'b1;
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.iAck) begin
                    w_next = S_RELEASE;
                end
            end
            S_RELEASE: begin
                // Both low required so a held iValid_Data cannot retrigger.
                if (!bus.iValid_Data && !bus.iAck) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q        <= '0;
            r_rem      <= '0;
            r_div      <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_quot_out <= '0;
            r_rem_out  <= '0;
        end else begin
            r_busy <= (w_next == S_RUN);
            r_done <= (w_next == S_DONE);
            if (w_start) begin
                r_q   <= bus.iDividend;
                r_div <= bus.iDivisor;
                r_rem <= '0;
                r_cnt <= CW'(WIDTH_N);
            end else if (r_state == S_RUN) begin
                r_q   <= w_q_next;
                r_rem <= w_rem_next;
                r_cnt <= r_cnt - CW'(1);
            end
            // Result registers change only when a new result lands.
            if (w_last) begin
                r_quot_out <= w_q_next;
                r_rem_out  <= w_rem_next[WIDTH_D-1:0];
            end else if (w_zero_skip) begin
                r_quot_out <= '1;
                r_rem_out  <= bus.iDividend[WIDTH_D-1:0];
            end
        end
    end

`ifdef DIVIDER_DIVZERO_CHECK_EN
    logic r_divzero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_divzero <= 1'b0;
        end else if (w_start) begin
            r_divzero <= w_zero_skip;
        end
    end

    assign bus.oDivZero = r_divzero;
`else
    assign bus.oDivZero = 1'b0;
`endif

    assign bus.oBusy      = r_busy;
    assign bus.oDone      = r_done;
    assign bus.oQuotient  = r_quot_out;
    assign bus.oRemainder = r_rem_out;

endmodule

`default_nettype wire

// File: doc/shift_sub_divider.md
# shift_sub_divider

- Sequential restoring shift-subtract divider; the inverse of the team's shift-add multiplier datapath.
- Takes a 64-bit dividend and a 32-bit divisor, e.g. a multiplier product and one of its operands.
- Produces a 64-bit quotient and 32-bit remainder, one quotient bit per clock.
- Uses the same iValid_Data/iAck handshake as the multiplier control machine, so a test generator or host can drive both blocks.

## Interface
- WIDTH_N, 64: dividend and quotient width.
- WIDTH_D, 32: divisor and remainder width.
- Clock  in  1  single clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low; low forces every register to its reset value immediately.
- iValid_Data  in  1  operands valid; sampled only in IDLE.
- iAck  in  1  host has consumed the result; sampled only in DONE.
- iDividend  in  WIDTH_N  dividend; captured on the start edge.
- iDivisor  in  WIDTH_D  divisor; captured on the start edge.
- oBusy  out  1  high in RUN.
- oDone  out  1  high in DONE; result valid and stable.
- oQuotient  out  WIDTH_N  quotient.
- oRemainder  out  WIDTH_D  remainder.
- oDivZero  out  1  divisor was zero; only with DIVIDER_DIVZERO_CHECK_EN, otherwise tied 0.

## Operation
- **States:** IDLE, RUN, DONE, RELEASE.
- **Reset values:** state IDLE; oBusy, oDone, oDivZero = 0; oQuotient, oRemainder = 0; internal partial remainder (WIDTH_D+1 bits) = 0; bit counter = 0.
- **IDLE:**
  - On iValid_Data=1: capture iDividend into the quotient shift register and iDivisor into the divisor register.
  - Clear the partial remainder, set the counter to WIDTH_N, go to RUN.
- **RUN, each edge:**
  - r' = {r[WIDTH_D-1:0], q[MSB]}; q shifts left.
  - If r' >= divisor: r = r' - divisor and q[0] = 1; else r = r' and q[0] = 0.
  - Counter decrements. When it reaches 0, go to DONE.
- **DONE:**
  - oDone = 1; oQuotient = q, oRemainder = r[WIDTH_D-1:0].
  - Hold until iAck=1 is sampled, then go to RELEASE.
- **RELEASE:** return to IDLE only when iValid_Data=0 and iAck=0 are sampled together. This prevents a held iValid_Data from retriggering.
- **Ignored inputs:**
  - iValid_Data in RUN, DONE and RELEASE.
  - iAck outside DONE.
  - Operand changes after the capture edge.
- **Result hold:** oQuotient and oRemainder keep the last result through RELEASE and IDLE until the next capture edge; they are not cleared.
- **Arithmetic:** unsigned only. The compare and subtract use WIDTH_D+1 bits, so no carry is lost.
- **Reset mid-operation:** Reset low in any state aborts and returns all reset values. The first operation after release from reset behaves normally.

## Timing
- **Start edge:** the rising edge where IDLE samples iValid_Data=1 is edge k; oBusy=1 after edge k.
- **Run length:** RUN takes exactly WIDTH_N edges (k+1 … k+64).
  - oBusy=0 and oDone=1 after edge k+64.
  - Start-to-done latency: 64 cycles.
- **Acknowledge:** iAck sampled high at edge m clears oDone after edge m.
- **Next start:** the earliest possible start is the edge after RELEASE sees both inputs low.
- **Registered outputs:** all outputs are registered; there are no combinational input-to-output paths.

## Configuration
- **Macro:** DIVIDER_DIVZERO_CHECK_EN.
- **Defined:**
  - A zero divisor seen on the start edge skips RUN and goes directly to DONE after edge k.
  - oQuotient = all ones, oRemainder = iDividend[WIDTH_D-1:0], oDivZero = 1.
  - oDivZero clears on the next capture edge or on reset.
- **Undefined:**
  - No check; a zero divisor runs the full 64 cycles.
  - The natural result is the same: quotient all ones, remainder = dividend[31:0].
  - oDivZero is constant 0.

## Test plan
- **Product inversion:** dividend 3495250, divisor 10 -> quotient 349525, remainder 0; oDone rises exactly 64 cycles after the start edge; oBusy high for 64 cycles.
- **Small operands:** 100 / 7 -> quotient 14, remainder 2. Then 0xFFFFFFFFFFFFFFFF / 0xFFFFFFFF -> quotient 0x0000000100000001, remainder 0.
- **Divide by zero:** dividend 0x123456789ABCDEF0, divisor 0.
  - With the macro: oDone after 1 cycle, oDivZero=1, quotient 0xFFFFFFFFFFFFFFFF, remainder 0x9ABCDEF0.
  - Without the macro: same values after 64 cycles, oDivZero=0.
- **Handshake:**
  - iAck pulsed during RUN is ignored.
  - iValid_Data held high through ack -> no second start until iValid_Data drops.
  - Result stays stable while oDone is high and for 20 cycles of delayed iAck.
- **Reset mid-run:** assert Reset low at RUN cycle 30 -> all outputs 0 asynchronously, state IDLE. After release, 1000 / 3 -> quotient 333, remainder 1 with normal 64-cycle latency.
